// File: rtl/fmul_pipe.sv
// Pipelined floating-point multiplier with tagged valid/ready handshakes.
// Denormal inputs flush to zero; results saturate to +/-Inf or flush to +/-0.
module fmul_pipe #(
  parameter int EW      = 8,
  parameter int MW      = 23,
  parameter int LATENCY = 2,
  parameter int ROUND   = 0,
  parameter int TAGW    = 5,
  localparam int W      = 1 + EW + MW
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    x1,
  input  logic [W-1:0]    x2,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    y,
  output logic [TAGW-1:0] out_tag,
  output logic            ovf,
  output logic            unf
);
  localparam int PW = 2 * MW + 2;
  localparam int EX = EW + 2;
  localparam int PS = (LATENCY >= 2) ? 1 : 0;
  localparam int RS = LATENCY - PS;
  localparam logic signed [EX-1:0] BIAS = EX'(2 ** (EW - 1) - 1);
  localparam logic signed [EX-1:0] EMAX = EX'(2 ** EW - 1);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high. The whole pipe advances together only when the output slot is empty or
  // being drained, so in_ready never depends on in_valid.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic [PW-1:0]          p_c;
  logic signed [EX-1:0]   e_c;
  logic                   s_c;
  logic                   z_c;

  always_comb begin
    p_c = PW'({1'b1, x1[MW-1:0]}) * PW'({1'b1, x2[MW-1:0]});
    e_c = $signed(EX'(x1[W-2:MW])) + $signed(EX'(x2[W-2:MW])) - BIAS;
    s_c = x1[W-1] ^ x2[W-1];
    z_c = (x1[W-2:MW] == '0) || (x2[W-2:MW] == '0);
  end

  logic [PW-1:0]          pa;
  logic signed [EX-1:0]   ea;
  logic                   sa;
  logic                   za;
  logic                   va;
  logic [TAGW-1:0]        ta;

  generate
    if (PS == 1) begin : g_pstage
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          pa <= '0;
          ea <= '0;
          sa <= 1'b0;
          za <= 1'b0;
          va <= 1'b0;
          ta <= '0;
        end else if (en) begin
          pa <= p_c;
          ea <= e_c;
          sa <= s_c;
          za <= z_c;
          va <= in_valid;
          ta <= in_tag;
        end
      end
    end else begin : g_pass
      assign pa = p_c;
      assign ea = e_c;
      assign sa = s_c;
      assign za = z_c;
      assign va = in_valid;
      assign ta = in_tag;
    end
  endgenerate

  // Normalise so the hidden bit sits just above pn's top; the dropped bits
  // feed guard/sticky for round-to-nearest-even.
  logic [PW-2:0]          pn;
  logic [MW-1:0]          mant;
  logic                   guard;
  logic                   sticky;
  logic                   inc;
  logic                   carry;
  logic signed [EX-1:0]   e_r;
  logic [W-1:0]           r_c;
  logic                   ovf_c;
  logic                   unf_c;

  always_comb begin
    pn            = pa[PW-1] ? pa[PW-2:0] : {pa[PW-3:0], 1'b0};
    guard         = pn[MW];
    sticky        = |pn[MW-1:0];
    inc           = (ROUND == 1) && guard && (sticky || pn[MW+1]);
    {carry, mant} = {1'b0, pn[PW-2:MW+1]} + (MW + 1)'(inc);
    e_r           = ea + EX'(pa[PW-1]) + EX'(carry);
    r_c           = {sa, {(W - 1){1'b0}}};
    ovf_c         = 1'b0;
    unf_c         = 1'b0;
    if (!za) begin
      if (e_r >= EMAX) begin
        r_c   = {sa, {EW{1'b1}}, {MW{1'b0}}};
        ovf_c = 1'b1;
      end else if (e_r <= 0) begin
        unf_c = 1'b1;
      end else begin
        r_c = {sa, e_r[EW-1:0], mant};
      end
    end
  end

  logic [W-1:0]    ry [RS];
  logic [TAGW-1:0] rt [RS];
  logic            rv [RS];
  logic            ro [RS];
  logic            ru [RS];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RS; i++) begin
        ry[i] <= '0;
        rt[i] <= '0;
        rv[i] <= 1'b0;
        ro[i] <= 1'b0;
        ru[i] <= 1'b0;
      end
    end else if (en) begin
      ry[0] <= r_c;
      rt[0] <= ta;
      rv[0] <= va;
      ro[0] <= ovf_c & va;
      ru[0] <= unf_c & va;
      for (int i = 1; i < RS; i++) begin
        ry[i] <= ry[i-1];
        rt[i] <= rt[i-1];
        rv[i] <= rv[i-1];
        ro[i] <= ro[i-1];
        ru[i] <= ru[i-1];
      end
    end
  end

  assign y         = ry[RS-1];
  assign out_tag   = rt[RS-1];
  assign out_valid = rv[RS-1];
  assign ovf       = ro[RS-1];
  assign unf       = ru[RS-1];
endmodule
